// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter
// Purpose : Round-robin IF/MEM arbiter and handshake sequencer for one shared
//           variable-latency unified memory, with a hung-access watchdog.
// Revision: 1.0
// ============================================================================
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ack_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              ram_req_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ready_i,
  output logic              stall_o,
  output logic              error_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic              OWN_IF     = 1'b0;
  localparam logic              OWN_MEM    = 1'b1;
  localparam logic [16:0]       TIMEOUT_C  = 17'(TIMEOUT);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [15:0]         wd_cnt_q, wd_cnt_d;
  logic                error_q, error_d;
  logic                if_ack_q, if_ack_d;
  logic                mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic                grant_mem;
  logic                to_resp;
  logic [DATA_W-1:0]   resp_data;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wd_cnt_d     = wd_cnt_q;
    error_d      = error_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;
    grant_mem    = 1'b0;
    to_resp      = 1'b0;
    resp_data    = '0;

    case (state_q)
      ST_IDLE: begin
        if (if_req_i || mem_req_i) begin
          // On a tie, the requester not served last time wins.
          grant_mem    = mem_req_i && (!if_req_i || (last_grant_q == OWN_IF));
          owner_d      = grant_mem ? OWN_MEM : OWN_IF;
          last_grant_d = grant_mem ? OWN_MEM : OWN_IF;
          addr_d       = grant_mem ? mem_addr_i  : if_addr_i;
          we_d         = grant_mem ? mem_we_i    : 1'b0;
          wdata_d      = grant_mem ? mem_wdata_i : '0;
          wd_cnt_d     = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (ram_ready_i) begin
          to_resp   = 1'b1;
          resp_data = we_q ? '0 : ram_rdata_i;
        end else if ((TIMEOUT_C != 17'd0) && (({1'b0, wd_cnt_q} + 17'd1) == TIMEOUT_C)) begin
          to_resp   = 1'b1;
          resp_data = ABORT_DATA;
          error_d   = 1'b1;
        end else begin
          wd_cnt_d  = wd_cnt_q + 16'd1;
        end
        // Ack and read data are registered here so both are valid throughout RESP.
        if (to_resp) begin
          state_d = ST_RESP;
          if (owner_q == OWN_MEM) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = resp_data;
          end else begin
            if_ack_d    = 1'b1;
            if_rdata_d  = resp_data;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_IF;
      owner_q      <= OWN_IF;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wd_cnt_q     <= '0;
      error_q      <= 1'b0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wd_cnt_q     <= wd_cnt_d;
      error_q      <= error_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  assign ram_req_o   = (state_q == ST_ISSUE);
  assign ram_we_o    = we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign if_ack_o    = if_ack_q;
  assign mem_ack_o   = mem_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign error_o     = error_q;
  assign stall_o     = (if_req_i && !if_ack_q) || (mem_req_i && !mem_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_unified_mem_arbiter
// Purpose : Directed self-checking bench for unified_mem_arbiter (TIMEOUT=4).
// Revision: 1.0
// ============================================================================
module tb_unified_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;
  logic              stall;
  logic              error;

  int n_checks = 0;
  int n_fail   = 0;

  unified_mem_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_ack_o   (if_ack),
    .if_rdata_o (if_rdata),
    .mem_req_i  (mem_req),
    .mem_we_i   (mem_we),
    .mem_addr_i (mem_addr),
    .mem_wdata_i(mem_wdata),
    .mem_ack_o  (mem_ack),
    .mem_rdata_o(mem_rdata),
    .ram_req_o  (ram_req),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata),
    .ram_ready_i(ram_ready),
    .stall_o    (stall),
    .error_o    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_addr = '0; mem_wdata = '0; ram_rdata = '0; ram_ready = 1'b0;

    // Reset state
    do_reset(2);
    check_value("rst_ram_req",   ram_req,   0);
    check_value("rst_ram_we",    ram_we,    0);
    check_value("rst_ram_addr",  ram_addr,  0);
    check_value("rst_ram_wdata", ram_wdata, 0);
    check_value("rst_if_ack",    if_ack,    0);
    check_value("rst_mem_ack",   mem_ack,   0);
    check_value("rst_if_rdata",  if_rdata,  0);
    check_value("rst_mem_rdata", mem_rdata, 0);
    check_value("rst_error",     error,     0);
    check_value("rst_stall",     stall,     0);

    // Single fetch, ready one cycle after ram_req
    if_req = 1'b1; if_addr = 32'h0000_0004;
    #1 check_value("f_stall_c0", stall, 1);
    step();
    check_value("f_ram_req",  ram_req,  1);
    check_value("f_ram_addr", ram_addr, 32'h4);
    check_value("f_ram_we",   ram_we,   0);
    check_value("f_stall_c1", stall,    1);
    ram_ready = 1'b1; ram_rdata = 32'h2008_0005;
    step();
    ram_ready = 1'b0;
    check_value("f_if_ack",   if_ack,   1);
    check_value("f_if_rdata", if_rdata, 32'h2008_0005);
    check_value("f_stall_ack", stall,   0);
    check_value("f_mem_ack",  mem_ack,  0);
    if_req = 1'b0;
    step();
    check_value("f_ack_drop", if_ack,  0);
    check_value("f_idle_req", ram_req, 0);

    // Write with ready after three ISSUE cycles
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h10; mem_wdata = 32'hCAFE_0001;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_value("w_ram_req",   ram_req,   1);
      check_value("w_ram_we",    ram_we,    1);
      check_value("w_ram_addr",  ram_addr,  32'h10);
      check_value("w_ram_wdata", ram_wdata, 32'hCAFE_0001);
      check_value("w_no_ack",    mem_ack,   0);
      if (i == 3) begin
        ram_ready = 1'b1; ram_rdata = 32'h5555_AAAA;
      end
    end
    step();
    ram_ready = 1'b0;
    check_value("w_mem_ack",   mem_ack,   1);
    check_value("w_mem_rdata", mem_rdata, 0);
    check_value("w_if_ack",    if_ack,    0);
    check_value("w_if_hold",   if_rdata,  32'h2008_0005);
    mem_req = 1'b0; mem_we = 1'b0;
    step();
    check_value("w_ack_single", mem_ack, 0);

    // Contention from reset: MEM, IF, MEM, IF
    do_reset(1);
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_wdata = '0;
    for (int g = 0; g < 4; g++) begin
      logic exp_mem;
      exp_mem = (g % 2 == 0);
      step();
      check_value("c_ram_req",  ram_req,  1);
      check_value("c_ram_addr", ram_addr, exp_mem ? 32'h200 : 32'h100);
      ram_ready = 1'b1; ram_rdata = 32'hA000_0000 | 32'(g);
      step();
      ram_ready = 1'b0;
      check_value("c_mem_ack", mem_ack, exp_mem);
      check_value("c_if_ack",  if_ack,  !exp_mem);
      check_value("c_rdata", exp_mem ? mem_rdata : if_rdata, 32'hA000_0000 | 32'(g));
      step();
      check_value("c_idle_req",   ram_req, 0);
      check_value("c_idle_stall", stall,   1);
    end
    if_req = 1'b0; mem_req = 1'b0;

    // Watchdog abort: ready never arrives
    if_req = 1'b1; if_addr = 32'h44;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_value("t_ram_req", ram_req, 1);
      check_value("t_error0",  error,   0);
    end
    step();
    check_value("t_if_ack",   if_ack,   1);
    check_value("t_if_rdata", if_rdata, 32'hDEAD_BEEF);
    check_value("t_error1",   error,    1);
    check_value("t_req_drop", ram_req,  0);
    if_req = 1'b0;
    step();
    step();
    check_value("t_error_sticky", error, 1);

    // Ready coincides with timeout cycle: ready wins
    do_reset(1);
    check_value("r_error_clr", error, 0);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h80;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_value("r_ram_req", ram_req, 1);
      if (i == 4) begin
        ram_ready = 1'b1; ram_rdata = 32'h1234_5678;
      end
    end
    step();
    ram_ready = 1'b0;
    check_value("r_mem_ack",   mem_ack,   1);
    check_value("r_mem_rdata", mem_rdata, 32'h1234_5678);
    check_value("r_error",     error,     0);
    mem_req = 1'b0;
    step();
    check_value("r_error_after", error, 0);

    // Reset while in ISSUE; MEM was last granted, so only reset makes MEM win the tie
    mem_req = 1'b1; mem_addr = 32'h90;
    step();
    check_value("m_ram_req", ram_req, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    mem_req = 1'b0;
    check_value("m_req_low",  ram_req, 0);
    check_value("m_no_ack",   mem_ack, 0);
    step();
    check_value("m_no_ack2",  mem_ack, 0);
    check_value("m_idle_req", ram_req, 0);
    if_req = 1'b1; if_addr = 32'h30;
    mem_req = 1'b1; mem_addr = 32'hA0;
    step();
    check_value("m_tie_addr", ram_addr, 32'hA0);
    ram_ready = 1'b1; ram_rdata = 32'h0BAD_F00D;
    step();
    ram_ready = 1'b0;
    check_value("m_tie_ack",   mem_ack,   1);
    check_value("m_tie_rdata", mem_rdata, 32'h0BAD_F00D);
    if_req = 1'b0; mem_req = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Sequencing controller that shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch stage and its data-memory stage. It arbitrates the two requesters round-robin and runs the request/ready handshake to the memory. It returns read data with a one-cycle acknowledge and drives a pipeline-wide stall while any access is outstanding. A watchdog aborts hung memory transactions and raises a sticky error flag.

## Interface
Parameters:
- `ADDR_W`, 32, address width (byte address, passed through unmodified).
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, maximum cycles in ISSUE without `ram_ready_i` before abort. A value of 0 disables the watchdog. Legal range is 0..65535.

Ports:
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `rst_i` in 1: reset, synchronous, active-low.
- `if_req_i` in 1: fetch request. Held high, with `if_addr_i` stable, until `if_ack_o`.
- `if_addr_i` in ADDR_W: fetch address.
- `if_ack_o` out 1: one-cycle pulse; `if_rdata_o` is valid in that cycle.
- `if_rdata_o` out DATA_W: fetched instruction.
- `mem_req_i` in 1: data request. Held high, with all attributes stable, until `mem_ack_o`.
- `mem_we_i` in 1: 1 means write, 0 means read.
- `mem_addr_i` in ADDR_W: data address.
- `mem_wdata_i` in DATA_W: store data.
- `mem_ack_o` out 1: one-cycle pulse.
- `mem_rdata_o` out DATA_W: load data, valid with `mem_ack_o` on reads.
- `ram_req_o` out 1: memory request. Held until `ram_ready_i`.
- `ram_we_o`, `ram_addr_o`, `ram_wdata_o` out 1/ADDR_W/DATA_W: latched attributes of the granted request.
- `ram_rdata_i` in DATA_W: memory read data, valid when `ram_ready_i`=1.
- `ram_ready_i` in 1: memory completion strobe.
- `stall_o` out 1: pipeline freeze. Combinational: (`if_req_i` & !`if_ack_o`) | (`mem_req_i` & !`mem_ack_o`).
- `error_o` out 1: sticky watchdog-abort flag.

## Operation
- Three-state FSM: IDLE, ISSUE, RESP.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one requester is high, grant it.
  - If both are high, grant the requester that was not granted last. `last_grant` resets to IF, so MEM wins the first tie.
  - On any grant: latch grant owner, address, we and wdata into registers; set `last_grant`; go to ISSUE.
  - IF grants always latch we=0 and wdata=0.
- ISSUE:
  - `ram_req_o`=1 and the ram_* attributes come from the latched registers. They stay stable for the whole state.
  - On `ram_ready_i`=1: capture `ram_rdata_i` into the response register (for writes, capture 0) and go to RESP.
  - Watchdog: a 16-bit counter clears on entry to ISSUE and increments each cycle without ready. If TIMEOUT≠0 and the counter reaches TIMEOUT: set `error_o`, load response = 32'hDEAD_BEEF, go to RESP. The memory sees `ram_req_o` drop.
- RESP:
  - Pulse the owner's ack for exactly one cycle and drive the owner's rdata from the response register.
  - Requests are ignored in RESP. Go to IDLE.
- The mandatory IDLE cycle after RESP lets the acknowledged requester drop `req`, so a stale request is never re-granted.
- Non-owner rdata outputs hold their last value. Rdata registers update only in RESP.
- `error_o` clears only on reset.
- A requester dropping `req` before its ack is a protocol violation. The transaction still completes to memory and the ack still pulses.

## Timing
- Reset values: state=IDLE, `last_grant`=IF, `ram_req_o`=0, `ram_we_o`=0, `ram_addr_o`=0, `ram_wdata_o`=0, both acks=0, both rdata=0, `error_o`=0, watchdog=0.
- Reset while in ISSUE or RESP takes effect at the edge. Any pending ack is lost and `ram_req_o` is 0 from the next cycle.
- Latency:
  - Request seen in IDLE at cycle 0 → `ram_req_o` high from cycle 1.
  - `ram_ready_i` at cycle k≥1 → ack at cycle k+1 → IDLE at cycle k+2.
  - Minimum is 2 cycles from request to ack.
  - Best-case throughput is one access per 3 cycles.
- With both requesters continuously active, grants strictly alternate.
- `ram_ready_i` outside ISSUE is ignored.
- `ram_ready_i` in the same cycle the watchdog reaches TIMEOUT: ready wins, the real data is returned, and `error_o` is not set.
- `stall_o` is combinational from the request inputs and registered acks, with no added delay. It falls in the ack cycle.

## Test plan
- Single fetch: `if_req_i`=1, addr=0x0000_0004, memory ready 1 cycle after `ram_req_o` with data 0x2008_0005 → `ram_addr_o`=0x4, `if_ack_o` pulses at cycle 2 with `if_rdata_o`=0x2008_0005, and `stall_o` is high in cycles 0–1.
- Write: mem we=1, addr=0x10, wdata=0xCAFE_0001, ready after 3 cycles → `ram_we_o`=1 and `ram_wdata_o`=0xCAFE_0001 held stable 3 cycles, then a single `mem_ack_o`.
- Contention: both requests high from reset, ready 1 cycle after each `ram_req_o` → grant order MEM, IF, MEM, IF, with each ack followed by one IDLE cycle.
- Timeout: TIMEOUT=4, `ram_ready_i` never asserted → `ram_req_o` high 4 cycles, then ack with rdata 0xDEAD_BEEF and `error_o`=1 held until reset.
- Ready/timeout tie: TIMEOUT=4, ready arrives on the 4th ISSUE cycle with data 0x1234_5678 → that data is returned and `error_o` stays 0.
- Reset mid-ISSUE: `rst_i`=0 for one cycle while `ram_req_o`=1 → next cycle `ram_req_o`=0, no ack, and the next tie is granted to MEM.
